// File: rtl/mips_pkg.sv
// Shared types for the core-side memory port arbiter.
package mips_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision: data wins unless fetch has lost STARVE_MAX arbitrations in a row.
module mem_arb_pick
  import mips_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int SW         = 3
) (
  input  logic          if_req,
  input  logic          d_req,
  input  logic [SW-1:0] starve_cnt,
  output owner_e        owner
);

  always_comb begin
    owner = OWN_NONE;
    if (if_req && starve_cnt == SW'(STARVE_MAX)) owner = OWN_IF;
    else if (d_req)                             owner = OWN_D;
    else if (if_req)                            owner = OWN_IF;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one single-port word memory
// through an IDLE -> ISSUE -> WAIT -> RESP handshake; all outputs registered.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int AW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [31:0]   if_rdata,
  output logic          if_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_done,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy,
  output logic [1:0]    owner
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_e    state, state_n;
  owner_e        pick, own_q, own_n;
  logic [SW-1:0] starve_cnt;
  logic [LW-1:0] lat_cnt;
  logic          we_q, we_n, err_q, err_n;
  logic [AW-1:0] sel_addr;
  logic          mis;

  mem_arb_pick #(.STARVE_MAX(STARVE_MAX), .SW(SW)) u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .starve_cnt (starve_cnt),
    .owner      (pick)
  );

  assign sel_addr = (pick == OWN_D) ? d_addr : if_addr;
  assign mis      = |sel_addr[1:0];
  assign owner    = own_q;

  always_comb begin
    state_n = state;
    own_n   = own_q;
    we_n    = we_q;
    err_n   = err_q;
    case (state)
      IDLE: begin
        if (pick != OWN_NONE) begin
          own_n   = pick;
          we_n    = (pick == OWN_D) && d_we;
          err_n   = mis;
          // Misaligned requests never touch memory.
          state_n = mis ? RESP : ISSUE;
        end
      end
      ISSUE:   state_n = WAIT;
      WAIT:    if (lat_cnt == LW'(MEM_LAT - 1)) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      own_q      <= OWN_NONE;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      starve_cnt <= '0;
      lat_cnt    <= '0;
      busy       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_done    <= 1'b0;
      if_err     <= 1'b0;
      if_rdata   <= '0;
      d_done     <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
    end else begin
      state   <= state_n;
      own_q   <= (state_n == IDLE) ? OWN_NONE : own_n;
      we_q    <= we_n;
      err_q   <= err_n;
      busy    <= (state_n != IDLE);
      lat_cnt <= (state == WAIT) ? lat_cnt + LW'(1) : '0;
      mem_en  <= (state_n == ISSUE);
      mem_we  <= (state_n == ISSUE) && we_n;

      if (state == IDLE && pick != OWN_NONE) begin
        mem_addr  <= sel_addr;
        mem_wdata <= (pick == OWN_D) ? d_wdata : '0;
        if (pick == OWN_IF)
          starve_cnt <= '0;
        else if (if_req && starve_cnt != SW'(STARVE_MAX))
          starve_cnt <= starve_cnt + SW'(1);
      end

      if_done <= (state_n == RESP) && (own_n == OWN_IF);
      if_err  <= (state_n == RESP) && (own_n == OWN_IF) && err_n;
      d_done  <= (state_n == RESP) && (own_n == OWN_D);
      d_err   <= (state_n == RESP) && (own_n == OWN_D) && err_n;

      // Memory data is valid in the last WAIT cycle, which is the cycle that enters RESP.
      if (state_n == RESP && own_n == OWN_IF)
        if_rdata <= err_n ? '0 : mem_rdata;
      if (state_n == RESP && own_n == OWN_D)
        d_rdata <= (err_n || we_n) ? '0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter at MEM_LAT=1, a second at MEM_LAT=3, each with a word memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic        if_done, if_err, d_done, d_err, mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  owner;

  logic        if2_req = 0, d2_req = 0, d2_we = 0;
  logic [31:0] if2_addr = 0, d2_addr = 0, d2_wdata = 0;
  logic        if2_done, if2_err, d2_done, d2_err, mem2_en, mem2_we, busy2;
  logic [31:0] if2_rdata, d2_rdata, mem2_addr, mem2_wdata, mem2_rdata;
  logic [1:0]  owner2;

  logic [31:0] mem1 [0:255];
  logic [31:0] mem2 [0:255];
  logic [31:0] rd1;
  logic [31:0] p2 [0:2];
  int          n_en1 = 0;
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .MEM_LAT(1), .STARVE_MAX(4)) u1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.AW(32), .MEM_LAT(3), .STARVE_MAX(4)) u2 (
    .clk(clk), .reset(reset),
    .if_req(if2_req), .if_addr(if2_addr), .if_done(if2_done), .if_rdata(if2_rdata), .if_err(if2_err),
    .d_req(d2_req), .d_we(d2_we), .d_addr(d2_addr), .d_wdata(d2_wdata),
    .d_done(d2_done), .d_rdata(d2_rdata), .d_err(d2_err),
    .mem_en(mem2_en), .mem_we(mem2_we), .mem_addr(mem2_addr), .mem_wdata(mem2_wdata),
    .mem_rdata(mem2_rdata), .busy(busy2), .owner(owner2)
  );

  // Memory contents: word i = A5A5A5_ii, except word 0 = 20020005.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem1[i] <= {24'hA5A5A5, 8'(i)};
      mem1[0] <= 32'h20020005;
      rd1     <= 32'hDEADBEEF;
      n_en1   <= 0;
    end else begin
      if (mem_en && mem_we) mem1[mem_addr[9:2]] <= mem_wdata;
      rd1 <= (mem_en && !mem_we) ? mem1[mem_addr[9:2]] : 32'hDEADBEEF;
      if (mem_en) n_en1 <= n_en1 + 1;
    end
  end
  assign mem_rdata = rd1;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem2[i] <= {24'hA5A5A5, 8'(i)};
      for (int k = 0; k < 3; k++) p2[k] <= 32'hDEADBEEF;
    end else begin
      if (mem2_en && mem2_we) mem2[mem2_addr[9:2]] <= mem2_wdata;
      p2[0] <= (mem2_en && !mem2_we) ? mem2[mem2_addr[9:2]] : 32'hDEADBEEF;
      p2[1] <= p2[0];
      p2[2] <= p2[1];
    end
  end
  assign mem2_rdata = p2[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int          g, viol, t1, t2, en_before;
    logic [9:0]  got;
    logic        prev, cur;
    logic [31:0] r1, r2;

    repeat (3) tick();
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_owner", {30'd0, owner}, 0);
    chk("rst_mem_en", {31'd0, mem_en}, 0);
    chk("rst_if_done", {31'd0, if_done}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);

    // Fetch only from 0x00
    if_addr = 32'h0; if_req = 1'b1;
    tick();
    chk("t1_mem_en_c1", {31'd0, mem_en}, 1);
    chk("t1_mem_we_c1", {31'd0, mem_we}, 0);
    chk("t1_mem_addr", mem_addr, 32'h0);
    chk("t1_owner", {30'd0, owner}, 1);
    chk("t1_busy", {31'd0, busy}, 1);
    tick();
    chk("t1_mem_en_c2", {31'd0, mem_en}, 0);
    chk("t1_if_done_c2", {31'd0, if_done}, 0);
    tick();
    chk("t1_if_done_c3", {31'd0, if_done}, 1);
    chk("t1_if_rdata", if_rdata, 32'h20020005);
    chk("t1_if_err", {31'd0, if_err}, 0);
    if_req = 1'b0;
    tick();
    chk("t1_done_drop", {31'd0, if_done}, 0);
    chk("t1_idle", {31'd0, busy}, 0);
    chk("t1_rdata_hold", if_rdata, 32'h20020005);

    // Store 7 to 84, then load it back
    d_addr = 32'd84; d_wdata = 32'd7; d_we = 1'b1; d_req = 1'b1;
    tick();
    chk("t2_mem_en", {31'd0, mem_en}, 1);
    chk("t2_mem_we", {31'd0, mem_we}, 1);
    chk("t2_mem_addr", mem_addr, 32'd84);
    chk("t2_mem_wdata", mem_wdata, 32'd7);
    chk("t2_owner", {30'd0, owner}, 2);
    tick(); tick();
    chk("t2_d_done", {31'd0, d_done}, 1);
    chk("t2_store_rdata", d_rdata, 0);
    d_req = 1'b0;
    tick();
    d_we = 1'b0; d_req = 1'b1;
    tick();
    chk("t2_load_we", {31'd0, mem_we}, 0);
    tick(); tick();
    chk("t2_load_done", {31'd0, d_done}, 1);
    chk("t2_load_rdata", d_rdata, 32'd7);
    d_req = 1'b0;
    tick();

    // Both requesters held: D,D,D,D,IF,D,D,D,D,IF
    if_addr = 32'h0; d_addr = 32'h40; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    g = 0; viol = 0; got = '0; prev = 1'b0;
    for (int c = 0; c < 200 && g < 10; c++) begin
      tick();
      cur = if_done | d_done;
      if (cur && prev) viol++;
      if (if_done && d_done) viol++;
      if (cur) begin
        got[g] = if_done;
        g++;
      end
      prev = cur;
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("t3_grants_seen", g, 10);
    chk("t3_grant_order", {22'd0, got}, {22'd0, 10'b10_0001_0000});
    chk("t3_pulse_width", viol, 0);
    chk("t3_if_rdata", if_rdata, 32'h20020005);
    chk("t3_d_rdata", d_rdata, 32'hA5A5A510);
    tick();

    // Misaligned data and fetch: done+err next cycle, no memory access
    en_before = n_en1;
    d_addr = 32'h52; d_req = 1'b1;
    tick();
    chk("t4_d_done", {31'd0, d_done}, 1);
    chk("t4_d_err", {31'd0, d_err}, 1);
    chk("t4_d_rdata", d_rdata, 0);
    chk("t4_no_mem_en", {31'd0, mem_en}, 0);
    d_req = 1'b0;
    tick();
    chk("t4_done_drop", {31'd0, d_done}, 0);
    if_addr = 32'h2; if_req = 1'b1;
    tick();
    chk("t4_if_done", {31'd0, if_done}, 1);
    chk("t4_if_err", {31'd0, if_err}, 1);
    if_req = 1'b0;
    tick();
    chk("t4_mem_en_count", n_en1 - en_before, 0);

    // Reset during WAIT
    if_addr = 32'h4; if_req = 1'b1;
    tick(); tick();
    chk("t5_busy_wait", {31'd0, busy}, 1);
    reset = 1'b1;
    if_req = 1'b0;
    tick();
    reset = 1'b0;
    chk("t5_busy", {31'd0, busy}, 0);
    chk("t5_owner", {30'd0, owner}, 0);
    chk("t5_no_done", {31'd0, if_done}, 0);
    chk("t5_rdata_clr", if_rdata, 0);
    tick();
    chk("t5_still_no_done", {31'd0, if_done}, 0);
    if_req = 1'b1;
    tick(); tick(); tick();
    chk("t5_fresh_done", {31'd0, if_done}, 1);
    chk("t5_fresh_rdata", if_rdata, 32'hA5A5A501);
    if_req = 1'b0;
    tick();

    // MEM_LAT=3 back-to-back loads
    d2_addr = 32'h40; d2_we = 1'b0; d2_req = 1'b1;
    t1 = -1; t2 = -1; r1 = '0; r2 = '0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (d2_done) begin
        if (t1 < 0) begin
          t1 = c; r1 = d2_rdata; d2_addr = 32'h44;
        end else begin
          t2 = c; r2 = d2_rdata; d2_req = 1'b0;
          break;
        end
      end
    end
    d2_req = 1'b0;
    chk("t6_first_latency", t1, 5);
    chk("t6_done_spacing", t2 - t1, 6);
    chk("t6_rdata_40", r1, 32'hA5A5A510);
    chk("t6_rdata_44", r2, 32'hA5A5A511);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
